cache_controller: RTL and testbench

//  Direct-mapped, write-through, no-write-allocate cache controller between the CPU's

---
 rtl/cache_pkg.sv | 22 ++
 rtl/cache_line_array.sv | 47 ++++
 rtl/cache_controller.sv | 205 ++++++++++++++++++++
 tb/tb_cache_controller.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and helpers for the direct-mapped write-through cache controller.
// Holds the FSM state encoding, index-width helper and saturating increment.
// No logic of its own; imported by the array and the controller.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    MEM_RD = 2'd2,
    MEM_WR = 2'd3
  } cache_state_t;

  function automatic int index_bits(input int lines);
    return $clog2(lines);
  endfunction

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/cache_line_array.sv
// Valid/tag/data storage for a direct-mapped cache, one word per line.
// Read is combinational by index; write and clear-all take effect on the next edge.
// Clear only touches valid bits and has priority over a same-cycle write.
module cache_line_array #(
  parameter int LINES      = 16,
  parameter int INDEX_BITS = 4,
  parameter int TAG_BITS   = 10,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [LINES-1:0]      valid_q;
  logic [TAG_BITS-1:0]   tag_mem  [LINES];
  logic [DATA_WIDTH-1:0] data_mem [LINES];

  // Valid bits: bulk clear (reset/flush) wins, otherwise a write marks the line resident.
  always_ff @(posedge clk) begin
    if (clear) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag/data payload is never reset; the valid bit alone qualifies it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache between CPU and sync RAM.
// Latency: read hit 2, read miss 2+MEM_LAT, write 3 cycles from request to cpu_ready.
// One access in flight; new requests accepted only in IDLE, cpu_ready is a single pulse.
module cache_controller
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 16,
  parameter int LINES      = 16,
  parameter int MEM_LAT    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ready,
  output logic                  cpu_hit,
  input  logic                  flush,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [15:0]           hit_count,
  output logic [15:0]           miss_count
);

  localparam int INDEX_BITS = index_bits(LINES);
  localparam int TAG_BITS   = ADDR_WIDTH - INDEX_BITS;
  localparam int CNT_W      = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  cache_state_t state_q, state_d;

  logic                  req_we_q, req_we_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [DATA_WIDTH-1:0] req_wdata_q, req_wdata_d;
  logic                  wr_hit_q, wr_hit_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0] cpu_rdata_d, mem_wdata_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic                  cpu_ready_d, cpu_hit_d, mem_cs_d, mem_we_d, mem_oe_d;
  logic [15:0]           hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  logic                  line_wr, flush_clr;
  logic [DATA_WIDTH-1:0] line_wr_data;
  logic                  rd_valid;
  logic [TAG_BITS-1:0]   rd_tag;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  hit;

  wire [INDEX_BITS-1:0] req_idx = req_addr_q[INDEX_BITS-1:0];
  wire [TAG_BITS-1:0]   req_tag = req_addr_q[ADDR_WIDTH-1:INDEX_BITS];

  assign hit = rd_valid && (rd_tag == req_tag);

  // Reset aborts an access without touching the line, and also clears every valid bit.
  cache_line_array #(
    .LINES      (LINES),
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lines (
    .clk      (clk),
    .clear    (rst | flush_clr),
    .wr_en    (line_wr & ~rst),
    .wr_idx   (req_idx),
    .wr_tag   (req_tag),
    .wr_data  (line_wr_data),
    .rd_idx   (req_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data)
  );

  // Next-state and next-output logic; registered outputs hold unless a state updates them.
  always_comb begin
    state_d      = state_q;
    req_we_d     = req_we_q;
    req_addr_d   = req_addr_q;
    req_wdata_d  = req_wdata_q;
    wr_hit_d     = wr_hit_q;
    cnt_d        = cnt_q;
    cpu_rdata_d  = cpu_rdata;
    cpu_ready_d  = 1'b0;
    cpu_hit_d    = 1'b0;
    mem_cs_d     = mem_cs;
    mem_we_d     = mem_we;
    mem_oe_d     = mem_oe;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    line_wr      = 1'b0;
    line_wr_data = mem_rdata;
    flush_clr    = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush) begin
          flush_clr = 1'b1;
        end else if (cpu_req) begin
          req_we_d    = cpu_we;
          req_addr_d  = cpu_addr;
          req_wdata_d = cpu_wdata;
          state_d     = LOOKUP;
        end
      end
      LOOKUP: begin
        if (req_we_q) begin
          mem_cs_d    = 1'b1;
          mem_we_d    = 1'b1;
          mem_oe_d    = 1'b0;
          mem_addr_d  = req_addr_q;
          mem_wdata_d = req_wdata_q;
          wr_hit_d    = hit;
          if (hit) hit_cnt_d = sat_inc(hit_cnt_q);
          state_d     = MEM_WR;
        end else if (hit) begin
          cpu_rdata_d = rd_data;
          cpu_ready_d = 1'b1;
          cpu_hit_d   = 1'b1;
          hit_cnt_d   = sat_inc(hit_cnt_q);
          state_d     = IDLE;
        end else begin
          mem_cs_d    = 1'b1;
          mem_oe_d    = 1'b1;
          mem_addr_d  = req_addr_q;
          cnt_d       = '0;
          miss_cnt_d  = sat_inc(miss_cnt_q);
          state_d     = MEM_RD;
        end
      end
      MEM_RD: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(MEM_LAT - 1)) begin
          line_wr     = 1'b1;
          cpu_rdata_d = mem_rdata;
          cpu_ready_d = 1'b1;
          mem_cs_d    = 1'b0;
          mem_oe_d    = 1'b0;
          state_d     = IDLE;
        end
      end
      MEM_WR: begin
        // No-write-allocate: only a resident line picks up the new word.
        line_wr      = wr_hit_q;
        line_wr_data = req_wdata_q;
        cpu_ready_d  = 1'b1;
        cpu_hit_d    = wr_hit_q;
        mem_cs_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_oe_d     = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, request latch and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      wr_hit_q    <= 1'b0;
      cnt_q       <= '0;
      cpu_rdata   <= '0;
      cpu_ready   <= 1'b0;
      cpu_hit     <= 1'b0;
      mem_cs      <= 1'b0;
      mem_we      <= 1'b0;
      mem_oe      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      wr_hit_q    <= wr_hit_d;
      cnt_q       <= cnt_d;
      cpu_rdata   <= cpu_rdata_d;
      cpu_ready   <= cpu_ready_d;
      cpu_hit     <= cpu_hit_d;
      mem_cs      <= mem_cs_d;
      mem_we      <= mem_we_d;
      mem_oe      <= mem_oe_d;
      mem_addr    <= mem_addr_d;
      mem_wdata   <= mem_wdata_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a behavioural RAM and a response scoreboard.
// Expected responses are queued when a request is driven and checked on cpu_ready.
// Inputs change and outputs are sampled on the falling edge.
module tb_cache_controller;
  import cache_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [13:0] cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic [15:0] cpu_rdata;
  logic        cpu_ready, cpu_hit;
  logic        flush = 1'b0;
  logic        mem_cs, mem_we, mem_oe;
  logic [13:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic [15:0] hit_count, miss_count;

  int compared   = 0;
  int mismatched = 0;

  typedef struct packed {
    logic        chk_data;
    logic [15:0] data;
    logic        hit;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;

  logic [15:0] ram [16384];

  always #5 clk = ~clk;

  cache_controller #(
    .ADDR_WIDTH (14),
    .DATA_WIDTH (16),
    .LINES      (16),
    .MEM_LAT    (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_ready  (cpu_ready),
    .cpu_hit    (cpu_hit),
    .flush      (flush),
    .mem_cs     (mem_cs),
    .mem_we     (mem_we),
    .mem_oe     (mem_oe),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  // RAM model: data valid in the cycle the address is presented; preloaded while in reset.
  assign mem_rdata = ram[mem_addr];
  always @(posedge clk) begin
    if (rst) begin
      ram[14'h010] <= 16'h1234;
      ram[14'h020] <= 16'h2222;
      ram[14'h031] <= 16'h0000;
    end else if (mem_cs && mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Response checker: pops the scoreboard on every completion pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (cpu_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_ready_qsize", sb_q.size(), 1);
        end else begin
          e = sb_q.pop_front();
          chk("rsp_hit", cpu_hit, e.hit);
          if (e.chk_data) chk("rsp_rdata", cpu_rdata, e.data);
        end
      end else begin
        chk("hit_outside_ready", cpu_hit, 0);
      end
    end
  end

  // One complete CPU access, called on a falling edge; tracks latency and RAM strobes.
  task automatic access(input string tag, input logic we, input logic [13:0] addr,
                        input logic [15:0] wdata, input logic [15:0] exp_rdata,
                        input logic exp_hit, input int exp_lat, input int exp_cs);
    int lat, cs_cyc, we_cyc;
    logic [13:0] we_addr;
    logic [15:0] we_dat;
    logic        we_oe, rd_oe_ok;
    bit          done;
    lat = 0; cs_cyc = 0; we_cyc = 0; done = 0;
    we_addr = '0; we_dat = '0; we_oe = 1'b1; rd_oe_ok = 1'b1;
    sb_q.push_back('{chk_data: !we, data: exp_rdata, hit: exp_hit});
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (mem_cs) cs_cyc++;
      if (mem_cs && !mem_we && !mem_oe) rd_oe_ok = 1'b0;
      if (mem_we) begin
        we_cyc++; we_addr = mem_addr; we_dat = mem_wdata; we_oe = mem_oe;
      end
      if (cpu_ready) done = 1;
    end
    cpu_req = 1'b0;
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_cs_cycles"}, cs_cyc, exp_cs);
    chk({tag, "_we_cycles"}, we_cyc, we ? 1 : 0);
    if (we) begin
      chk({tag, "_we_addr"}, we_addr, addr);
      chk({tag, "_we_data"}, we_dat, wdata);
      chk({tag, "_we_oe"}, we_oe, 0);
    end else begin
      chk({tag, "_rd_oe"}, rd_oe_ok, 1);
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", cpu_ready, 0);
    chk("rst_hit", cpu_hit, 0);
    chk("rst_cs", mem_cs, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_oe", mem_oe, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_maddr", mem_addr, 0);
    chk("rst_mwdata", mem_wdata, 0);
    chk("rst_hitcnt", hit_count, 0);
    chk("rst_misscnt", miss_count, 0);
    rst = 1'b0;
    @(negedge clk);

    // Cold read miss, then hit
    access("rd_miss_010", 1'b0, 14'h010, 16'h0, 16'h1234, 1'b0, 3, 1);
    chk("miss_cnt_1", miss_count, 1);
    access("rd_hit_010", 1'b0, 14'h010, 16'h0, 16'h1234, 1'b1, 2, 0);
    chk("hit_cnt_1", hit_count, 1);

    // Conflict eviction on index 0
    access("rd_miss_020", 1'b0, 14'h020, 16'h0, 16'h2222, 1'b0, 3, 1);
    access("rd_miss_010b", 1'b0, 14'h010, 16'h0, 16'h1234, 1'b0, 3, 1);
    chk("miss_cnt_3", miss_count, 3);

    // Write-through to a resident line, then no-write-allocate
    access("wr_hit_010", 1'b1, 14'h010, 16'hBEEF, 16'h0, 1'b1, 3, 1);
    chk("ram_010", ram[14'h010], 16'hBEEF);
    access("rd_hit_beef", 1'b0, 14'h010, 16'h0, 16'hBEEF, 1'b1, 2, 0);
    chk("hit_cnt_3", hit_count, 3);
    access("wr_miss_031", 1'b1, 14'h031, 16'h5555, 16'h0, 1'b0, 3, 1);
    chk("ram_031", ram[14'h031], 16'h5555);
    access("rd_miss_031", 1'b0, 14'h031, 16'h0, 16'h5555, 1'b0, 3, 1);
    chk("miss_cnt_4", miss_count, 4);

    // Flush beats a simultaneous request; the request then misses
    flush = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h010;
    @(negedge clk);
    chk("flush_state", dut.state_q, IDLE);
    chk("flush_cs", mem_cs, 0);
    flush = 1'b0;
    access("rd_after_flush", 1'b0, 14'h010, 16'h0, 16'hBEEF, 1'b0, 3, 1);
    chk("miss_cnt_5", miss_count, 5);

    // Reset in the middle of a read miss
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h020;
    repeat (2) @(negedge clk);
    chk("mid_memrd_cs", mem_cs, 1);
    rst = 1'b1; cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_cs", mem_cs, 0);
    chk("abort_ready", cpu_ready, 0);
    chk("abort_hitcnt", hit_count, 0);
    chk("abort_misscnt", miss_count, 0);
    chk("abort_state", dut.state_q, IDLE);
    access("rd_after_rst", 1'b0, 14'h010, 16'h0, 16'h1234, 1'b0, 3, 1);
    chk("miss_cnt_after_rst", miss_count, 1);

    // Hit counter saturation, starting just below the ceiling
    @(negedge clk);
    force dut.hit_cnt_q = 16'hFFFC;
    #1 release dut.hit_cnt_q;
    for (int i = 0; i < 3; i++)
      access("rd_hit_sat", 1'b0, 14'h010, 16'h0, 16'h1234, 1'b1, 2, 0);
    chk("hit_cnt_ffff", hit_count, 16'hFFFF);
    for (int i = 0; i < 2; i++)
      access("rd_hit_sat2", 1'b0, 14'h010, 16'h0, 16'h1234, 1'b1, 2, 0);
    chk("hit_cnt_held", hit_count, 16'hFFFF);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
